// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instruction_fetch                                            |
// | Description : RV32I fetch stage. Sequences the PC, reads a 1-cycle sync    |
// |               imem, buffers {instr, pc} in a DEPTH-entry FIFO for decode.  |
// |               Optional macro FETCH_MISALIGN_CHECK_EN halts on misaligned   |
// |               redirect targets and raises fetch_misaligned.                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_misaligned
);

  localparam int            C_AW    = $clog2(DEPTH);
  localparam logic [C_AW:0] C_DEPTH = (C_AW+1)'(DEPTH);
  localparam logic [31:0]   C_STEP  = 32'd4;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t r_state;
  logic   r_fault;
`endif

  logic [31:0]     r_fetch_pc;
  logic            r_inflight;
  logic [31:0]     r_inflight_pc;
  logic [31:0]     r_buf_instr [DEPTH];
  logic [31:0]     r_buf_pc    [DEPTH];
  logic [C_AW-1:0] r_rd_ptr;
  logic [C_AW-1:0] r_wr_ptr;
  logic [C_AW:0]   r_count;

  logic            w_pop;
  logic            w_push;
  logic            w_misalign;
  logic            w_halted;
  logic            w_issue;
  logic [C_AW:0]   w_occ;
  logic [31:0]     w_target;

  assign w_target = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_misalign       = redirect && (redirect_pc[1:0] != 2'b00);
  assign w_halted         = (r_state == ST_HALT);
  assign fetch_misaligned = r_fault;
`else
  assign w_misalign       = 1'b0;
  assign w_halted         = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

  assign instr_valid = (r_count != '0);
  assign instr       = instr_valid ? r_buf_instr[r_rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? r_buf_pc[r_rd_ptr]    : 32'h0;

  assign w_pop  = instr_valid && instr_ready;
  // Data returning during a redirect belongs to the abandoned path.
  assign w_push = r_inflight && !redirect;

  // Occupancy counts the in-flight read so a slot is reserved for its data.
  assign w_occ   = r_count + (C_AW+1)'(r_inflight) - (C_AW+1)'(w_pop);
  assign w_issue = !w_halted && (w_occ < C_DEPTH);

  assign imem_req  = !rst && (redirect ? !w_misalign : w_issue);
  assign imem_addr = redirect ? w_target : r_fetch_pc;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_instr[r_wr_ptr] <= imem_rdata;
      r_buf_pc[r_wr_ptr]    <= r_inflight_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      r_state       <= ST_RUN;
      r_fault       <= 1'b0;
`endif
    end else if (redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (w_misalign) begin
        r_state    <= ST_HALT;
        r_fault    <= 1'b1;
        r_inflight <= 1'b0;
      end else begin
        r_state       <= ST_RUN;
        r_fault       <= 1'b0;
        r_fetch_pc    <= w_target + C_STEP;
        r_inflight    <= 1'b1;
        r_inflight_pc <= w_target;
      end
`else
      r_fetch_pc    <= w_target + C_STEP;
      r_inflight    <= 1'b1;
      r_inflight_pc <= w_target;
`endif
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_AW'(1);
      end
      r_count <= r_count + (C_AW+1)'(w_push) - (C_AW+1)'(w_pop);
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + C_STEP;
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_fetch_pc;
      end else begin
        r_inflight    <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instruction_fetch                                         |
// | Description : Directed self-checking bench for instruction_fetch with a    |
// |               1-cycle memory returning addr ^ 0xA5A5_0000.                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_instruction_fetch;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0100;
  localparam int          C_DEPTH    = 2;
  localparam logic [31:0] C_KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_misaligned;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;

  instruction_fetch #(
    .RESET_PC (C_RESET_PC),
    .DEPTH    (C_DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_ready      (instr_ready),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  always #5 clk = ~clk;

  // Synchronous memory model: data for a request appears one cycle later.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr ^ C_KEY) : 32'hDEAD_BEEF;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Checks that the head is the word fetched from address e.
  task automatic chk_head(input string nm, input logic [31:0] e);
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== e || instr !== (e ^ C_KEY)) begin
      n_fail++;
      $display("FAIL %s: got valid=%b pc=%h instr=%h want valid=1 pc=%h instr=%h",
               nm, instr_valid, instr_pc, instr, e, e ^ C_KEY);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr_ready = 1'b1;
    repeat (3) cyc();
    #1;
    n_checks++;
    if ({instr_valid, imem_req, fetch_misaligned} !== 3'b000 || instr !== 32'h0 || instr_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: got valid=%b req=%b mis=%b instr=%h pc=%h want all zero",
               instr_valid, imem_req, fetch_misaligned, instr, instr_pc);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== C_RESET_PC) begin
      n_fail++;
      $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, C_RESET_PC);
    end
    cyc();
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== C_RESET_PC + 32'd4) begin
      n_fail++;
      $display("FAIL reset_cycle1: got valid=%b req=%b addr=%h want valid=0 req=1 addr=%h",
               instr_valid, imem_req, imem_addr, C_RESET_PC + 32'd4);
    end
    exp_pc = C_RESET_PC;
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      chk_head("reset_stream", exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      cyc();
      instr_ready = 1'b0;
      #1;
      chk_head("stall_head_hold", exp_pc);
      n_checks++;
      if (imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_req_low: got req=%b want 0 (cycle %0d)", imem_req, i);
      end
    end
    cyc();
    instr_ready = 1'b1;
    #1;
    chk_head("resume_head", exp_pc);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_pc + 32'd4 * C_DEPTH) begin
      n_fail++;
      $display("FAIL resume_req: got req=%b addr=%h want req=1 addr=%h",
               imem_req, imem_addr, exp_pc + 32'd4 * C_DEPTH);
    end
    exp_pc = exp_pc + 32'd4;
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      chk_head("resume_stream", exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_redirect_full();
    cyc();
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin
      n_fail++;
      $display("FAIL redirect_same_cycle: got req=%b addr=%h want req=1 addr=00000200", imem_req, imem_addr);
    end
    cyc();
    redirect    = 1'b0;
    instr_ready = 1'b1;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_flush: got valid=%b pc=%h want valid=0", instr_valid, instr_pc);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      chk_head("redirect_stream", 32'h0000_0200 + 32'd4 * k);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      cyc();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0300 + 32'h100 * i;
      #1;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== redirect_pc || (i > 0 && instr_valid !== 1'b0)) begin
        n_fail++;
        $display("FAIL b2b_redirect: got req=%b addr=%h valid=%b want req=1 addr=%h",
                 imem_req, imem_addr, instr_valid, redirect_pc);
      end
    end
    cyc();
    redirect = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: got valid=%b pc=%h want valid=0", instr_valid, instr_pc);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      chk_head("b2b_stream", 32'h0000_0500 + 32'd4 * k);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    #1;
    cyc();
    redirect = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_req: got req=%b addr=%h want req=1 addr=fffffffc", imem_req, imem_addr);
    end
    e = 32'hFFFF_FFF8;
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      chk_head("wrap_stream", e);
      e = e + 32'd4;
    end
  endtask

  task automatic test_misalign();
`ifdef FETCH_MISALIGN_CHECK_EN
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0202;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_no_req: got req=%b want 0", imem_req);
    end
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      n_checks++;
      if (fetch_misaligned !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign_halt: got mis=%b valid=%b req=%b want mis=1 valid=0 req=0",
                 fetch_misaligned, instr_valid, imem_req);
      end
    end
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0300) begin
      n_fail++;
      $display("FAIL misalign_restart_req: got req=%b addr=%h want req=1 addr=00000300", imem_req, imem_addr);
    end
    cyc();
    redirect = 1'b0;
    #1;
    n_checks++;
    if (fetch_misaligned !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_clear: got mis=%b valid=%b want mis=0 valid=0", fetch_misaligned, instr_valid);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      chk_head("misalign_restart_stream", 32'h0000_0300 + 32'd4 * k);
    end
`else
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0202;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200 || fetch_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_masked_req: got req=%b addr=%h mis=%b want req=1 addr=00000200 mis=0",
               imem_req, imem_addr, fetch_misaligned);
    end
    cyc();
    redirect = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      chk_head("misalign_masked_stream", 32'h0000_0200 + 32'd4 * k);
      n_checks++;
      if (fetch_misaligned !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign_tied_low: got mis=%b want 0", fetch_misaligned);
      end
    end
`endif
  endtask

  task automatic test_reset_midstream();
    cyc();
    rst = 1'b1;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_async: got valid=%b req=%b instr=%h pc=%h want all zero",
               instr_valid, imem_req, instr, instr_pc);
    end
    cyc();
    rst = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== C_RESET_PC) begin
      n_fail++;
      $display("FAIL midreset_restart: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, C_RESET_PC);
    end
    cyc();
    #1;
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_stale: got valid=%b pc=%h want valid=0", instr_valid, instr_pc);
    end
    for (int k = 0; k < 2; k++) begin
      cyc();
      #1;
      chk_head("midreset_stream", C_RESET_PC + 32'd4 * k);
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect_full();
    test_back_to_back();
    test_wrap();
    test_misalign();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
